// File: rtl/pran_ctrl_pkg.sv
// Shared control encodings for the PRAN RV32I multicycle core: opcodes,
// main FSM state codes, and the mux/ALUOp encodings that the ALU decoder
// and datapath agree on.
package pran_ctrl_pkg;

   // Opcodes, Instr[6:0]
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // ALUOp
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALUSrcA
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   // ALUSrcB
   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // ResultSrc
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALRADR  = 4'd11,
      S_LUI      = 4'd12,
      S_AUIPC    = 4'd13
   } state_t;

   // Ungated control word; FETCH's IRWrite/PCUpdate still need MemReady.
   typedef struct packed {
      logic       pc_update;
      logic       branch;
      logic       reg_write;
      logic       mem_write;
      logic       ir_write;
      logic       adr_src;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
   } ctrl_t;

endpackage

// File: rtl/main_fsm_outputs.sv
// Combinational state -> control-word decode for main_fsm.
// Optional: PRAN_UPPER_IMM_EN adds the LUI and AUIPC states.
import pran_ctrl_pkg::*;

module main_fsm_outputs (
   input  state_t i_state,
   output ctrl_t  o_ctrl
);

   // Decode control word; anything not set stays 0.
   always_comb begin
      o_ctrl = '0;
      case (i_state)
         S_FETCH: begin
            o_ctrl.ir_write   = 1'b1;
            o_ctrl.pc_update  = 1'b1;
            o_ctrl.alu_src_a  = SRCA_PC;
            o_ctrl.alu_src_b  = SRCB_FOUR;
            o_ctrl.alu_op     = ALUOP_ADD;
            o_ctrl.result_src = RES_ALURES;
         end
         S_DECODE: begin
            o_ctrl.alu_src_a = SRCA_OLDPC;
            o_ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMADR, S_JALRADR: begin
            o_ctrl.alu_src_a = SRCA_RD1;
            o_ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMREAD: begin
            o_ctrl.adr_src    = 1'b1;
            o_ctrl.result_src = RES_ALUOUT;
         end
         S_MEMWB: begin
            o_ctrl.result_src = RES_DATA;
            o_ctrl.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            o_ctrl.adr_src    = 1'b1;
            o_ctrl.result_src = RES_ALUOUT;
            o_ctrl.mem_write  = 1'b1;
         end
         S_EXECUTER: begin
            o_ctrl.alu_src_a = SRCA_RD1;
            o_ctrl.alu_src_b = SRCB_RD2;
            o_ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            o_ctrl.alu_src_a = SRCA_RD1;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            o_ctrl.result_src = RES_ALUOUT;
            o_ctrl.reg_write  = 1'b1;
         end
         S_BRANCH: begin
            o_ctrl.alu_src_a  = SRCA_RD1;
            o_ctrl.alu_src_b  = SRCB_RD2;
            o_ctrl.alu_op     = ALUOP_SUB;
            o_ctrl.result_src = RES_ALUOUT;
            o_ctrl.branch     = 1'b1;
         end
         // PC loads the target held in ALUOut while ALU forms OldPC+4 for rd.
         S_JAL: begin
            o_ctrl.alu_src_a  = SRCA_OLDPC;
            o_ctrl.alu_src_b  = SRCB_FOUR;
            o_ctrl.result_src = RES_ALUOUT;
            o_ctrl.pc_update  = 1'b1;
         end
`ifdef PRAN_UPPER_IMM_EN
         S_LUI: begin
            o_ctrl.alu_src_a = SRCA_ZERO;
            o_ctrl.alu_src_b = SRCB_IMM;
         end
         S_AUIPC: begin
            o_ctrl.alu_src_a = SRCA_OLDPC;
            o_ctrl.alu_src_b = SRCB_IMM;
         end
`endif
         default: o_ctrl = '0;
      endcase
   end

endmodule

// File: rtl/main_fsm.sv
// Multicycle main control FSM for the PRAN RV32I core.
// Holds the state register, next-state logic and MemReady gating; control
// word decode lives in main_fsm_outputs.
// Optional: PRAN_UPPER_IMM_EN makes DECODE accept LUI and AUIPC.
import pran_ctrl_pkg::*;

module main_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       MemReady,
   output logic       PCUpdate,
   output logic       Branch,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       IllegalOp
);

   state_t r_state;
   state_t w_decode_nxt;
   logic   w_illegal;
   logic   w_fetch;
   ctrl_t  w_ctrl;

   main_fsm_outputs u_outputs (
      .i_state (r_state),
      .o_ctrl  (w_ctrl)
   );

   // Opcode dispatch out of DECODE; unknown opcodes bounce back to FETCH.
   always_comb begin
      w_decode_nxt = S_FETCH;
      w_illegal    = 1'b0;
      case (op)
         OP_LOAD, OP_STORE: w_decode_nxt = S_MEMADR;
         OP_RTYPE:          w_decode_nxt = S_EXECUTER;
         OP_ITYPE:          w_decode_nxt = S_EXECUTEI;
         OP_BRANCH:         w_decode_nxt = S_BRANCH;
         OP_JAL:            w_decode_nxt = S_JAL;
         OP_JALR:           w_decode_nxt = S_JALRADR;
`ifdef PRAN_UPPER_IMM_EN
         OP_LUI:            w_decode_nxt = S_LUI;
         OP_AUIPC:          w_decode_nxt = S_AUIPC;
`endif
         default:           w_illegal    = 1'b1;
      endcase
   end

   // State register; reset overrides every transition, stalls included.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         case (r_state)
            S_FETCH:    if (MemReady) r_state <= S_DECODE;
            S_DECODE:   r_state <= w_decode_nxt;
            S_MEMADR:   r_state <= op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (MemReady) r_state <= S_MEMWB;
            S_MEMWB:    r_state <= S_FETCH;
            S_MEMWRITE: if (MemReady) r_state <= S_FETCH;
            S_EXECUTER: r_state <= S_ALUWB;
            S_EXECUTEI: r_state <= S_ALUWB;
            S_ALUWB:    r_state <= S_FETCH;
            S_BRANCH:   r_state <= S_FETCH;
            S_JALRADR:  r_state <= S_JAL;
            S_JAL:      r_state <= S_ALUWB;
            S_LUI:      r_state <= S_ALUWB;
            S_AUIPC:    r_state <= S_ALUWB;
            default:    r_state <= S_FETCH;
         endcase
      end
   end

   // FETCH only commits the instruction once memory has returned it.
   assign w_fetch   = (r_state == S_FETCH);
   assign IRWrite   = w_ctrl.ir_write & MemReady;
   assign PCUpdate  = w_ctrl.pc_update & (~w_fetch | MemReady);
   assign Branch    = w_ctrl.branch;
   assign RegWrite  = w_ctrl.reg_write;
   assign MemWrite  = w_ctrl.mem_write;
   assign AdrSrc    = w_ctrl.adr_src;
   assign ResultSrc = w_ctrl.result_src;
   assign ALUSrcA   = w_ctrl.alu_src_a;
   assign ALUSrcB   = w_ctrl.alu_src_b;
   assign ALUOp     = w_ctrl.alu_op;
   assign IllegalOp = (r_state == S_DECODE) & w_illegal;

endmodule
